// File: rtl/waveform_scope_renderer.sv
// waveform_scope_renderer
//   Pixel-stage consumer of the video timing generator. Decimated audio
//   samples are captured one column at a time into a ping-pong column buffer
//   (one row index per column). The finished bank is drawn as a green scope
//   trace over a grey centre line. Banks swap only at new_frame, so the
//   displayed trace never tears.
// Ports
//   pixel_clk, rst              clock; synchronous active-high reset
//   h_count, v_count            timing-generator counters
//   active_draw, new_frame      active region; 1-cycle end-of-frame pulse
//   sample_in, sample_valid     signed audio sample and its qualifier
//   freeze                      hold the displayed trace (no bank swap)
//   red, green, blue            pixel colour, 2 cycles after the counts
//   hsync, vsync                active-high syncs, same 2-cycle latency
//   active_draw_out             active_draw aligned with the colour
//   frame_captured              1-cycle pulse on every bank swap
module waveform_scope_renderer #(
  parameter int ACTIVE_H_PIXELS = 1280,
  parameter int ACTIVE_LINES    = 720,
  parameter int H_FRONT_PORCH   = 110,
  parameter int H_SYNC_WIDTH    = 40,
  parameter int V_FRONT_PORCH   = 5,
  parameter int V_SYNC_WIDTH    = 5,
  parameter int H_COUNT_WIDTH   = 11,
  parameter int V_COUNT_WIDTH   = 10,
  parameter int SAMPLE_WIDTH    = 16,
  parameter int DECIMATE        = 16
) (
  input  logic                            pixel_clk,
  input  logic                            rst,
  input  logic [H_COUNT_WIDTH-1:0]        h_count,
  input  logic [V_COUNT_WIDTH-1:0]        v_count,
  input  logic                            active_draw,
  input  logic                            new_frame,
  input  logic signed [SAMPLE_WIDTH-1:0]  sample_in,
  input  logic                            sample_valid,
  input  logic                            freeze,
  output logic [7:0]                      red,
  output logic [7:0]                      green,
  output logic [7:0]                      blue,
  output logic                            hsync,
  output logic                            vsync,
  output logic                            active_draw_out,
  output logic                            frame_captured
);

  localparam int CW = (ACTIVE_H_PIXELS > 1) ? $clog2(ACTIVE_H_PIXELS) : 1;
  localparam int DW = (DECIMATE > 1) ? $clog2(DECIMATE) : 1;
  localparam int RW = V_COUNT_WIDTH;
  localparam int PW = SAMPLE_WIDTH + V_COUNT_WIDTH + 2;

  localparam logic signed [PW-1:0] HALF_S = PW'(ACTIVE_LINES / 2);
  localparam logic signed [PW-1:0] LAST_S = PW'(ACTIVE_LINES - 1);
  localparam logic [RW-1:0] HALF_V   = RW'(ACTIVE_LINES / 2);
  localparam logic [RW-1:0] LAST_ROW = RW'(ACTIVE_LINES - 1);
  localparam logic [CW-1:0] LAST_COL = CW'(ACTIVE_H_PIXELS - 1);
  localparam logic [DW-1:0] DEC_LAST = DW'(DECIMATE - 1);
  localparam logic [H_COUNT_WIDTH-1:0] H_ACT    = H_COUNT_WIDTH'(ACTIVE_H_PIXELS);
  localparam logic [H_COUNT_WIDTH-1:0] HS_START = H_COUNT_WIDTH'(ACTIVE_H_PIXELS + H_FRONT_PORCH);
  localparam logic [H_COUNT_WIDTH-1:0] HS_END   = H_COUNT_WIDTH'(ACTIVE_H_PIXELS + H_FRONT_PORCH + H_SYNC_WIDTH);
  localparam logic [V_COUNT_WIDTH-1:0] VS_START = V_COUNT_WIDTH'(ACTIVE_LINES + V_FRONT_PORCH);
  localparam logic [V_COUNT_WIDTH-1:0] VS_END   = V_COUNT_WIDTH'(ACTIVE_LINES + V_FRONT_PORCH + V_SYNC_WIDTH);

  typedef enum logic [1:0] {ARMED, CAPTURING, DONE} state_t;

  state_t          state_q, state_d;
  logic            wr_bank_q, wr_bank_d;
  logic            trace_valid_q, trace_valid_d;
  logic [DW-1:0]   decim_q, decim_d;
  logic [CW-1:0]   col_q, col_d;
  logic            arm_q, arm_d;        // one new_frame already seen in ARMED
  logic            prev_neg_q, prev_neg_d;
  logic            fc_q, fc_d;
  logic            we;

  // ---------------- sample -> row mapping ----------------
  logic signed [PW-1:0] prod, row_s;
  logic [RW-1:0]        row;

  always_comb begin
    prod  = PW'(sample_in) * HALF_S;
    row_s = HALF_S - (prod >>> (SAMPLE_WIDTH - 1));
    if (row_s[PW-1])        row = '0;
    else if (row_s > LAST_S) row = LAST_ROW;
    else                     row = row_s[RW-1:0];
  end

  // ---------------- capture FSM ----------------
  logic use_smp, trig;
  assign use_smp = sample_valid && (decim_q == '0);
  assign trig    = use_smp && prev_neg_q && !sample_in[SAMPLE_WIDTH-1];

  always_comb begin
    state_d       = state_q;
    wr_bank_d     = wr_bank_q;
    trace_valid_d = trace_valid_q;
    decim_d       = decim_q;
    col_d         = col_q;
    arm_d         = arm_q;
    prev_neg_d    = prev_neg_q;
    fc_d          = 1'b0;
    we            = 1'b0;

    if (sample_valid) decim_d = (decim_q == DEC_LAST) ? '0 : decim_q + 1'b1;
    if (use_smp)      prev_neg_d = sample_in[SAMPLE_WIDTH-1];

    unique case (state_q)
      ARMED: begin
        // A real trigger wins over the auto-trigger in the same cycle.
        if (trig) begin
          state_d = CAPTURING;
          decim_d = '0;
          arm_d   = 1'b0;
          we      = 1'b1;
        end else if (new_frame) begin
          if (arm_q) begin
            state_d = CAPTURING;
            decim_d = '0;
            arm_d   = 1'b0;
          end else begin
            arm_d = 1'b1;
          end
        end
      end
      CAPTURING: if (use_smp) we = 1'b1;
      DONE: begin
        if (new_frame && !freeze) begin
          state_d       = ARMED;
          wr_bank_d     = !wr_bank_q;
          trace_valid_d = 1'b1;
          fc_d          = 1'b1;
          arm_d         = 1'b0;
        end
      end
      default: state_d = ARMED;
    endcase

    // col_q is 0 whenever ARMED, so the trigger sample lands in column 0.
    if (we) begin
      if (col_q == LAST_COL) begin
        state_d = DONE;
        col_d   = '0;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      state_q       <= ARMED;
      wr_bank_q     <= 1'b0;
      trace_valid_q <= 1'b0;
      decim_q       <= '0;
      col_q         <= '0;
      arm_q         <= 1'b0;
      prev_neg_q    <= 1'b0;
      fc_q          <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_bank_q     <= wr_bank_d;
      trace_valid_q <= trace_valid_d;
      decim_q       <= decim_d;
      col_q         <= col_d;
      arm_q         <= arm_d;
      prev_neg_q    <= prev_neg_d;
      fc_q          <= fc_d;
    end
  end

  assign frame_captured = fc_q;

  // ---------------- ping-pong column buffer ----------------
  // Not cleared by reset; trace_valid keeps stale contents off screen.
  logic [RW-1:0] mem [2][ACTIVE_H_PIXELS];
  logic [RW-1:0] rd_q;
  logic          h_in;

  assign h_in = (h_count < H_ACT);

  always_ff @(posedge pixel_clk) begin
    if (we && !rst) mem[wr_bank_q][col_q] <= row;
    if (h_in)       rd_q <= mem[!wr_bank_q][h_count[CW-1:0]];
  end

  // ---------------- render pipeline ----------------
  // stage 1 holds the counts alongside the RAM read; stage 2 is the outputs.
  logic [RW-1:0] s1_v_q;
  logic          s1_ad_q, s1_hs_q, s1_vs_q, s1_in_q, s1_tv_q;
  logic [23:0]   rgb_d, rgb_q;
  logic          hs_q, vs_q, ad_q;

  always_comb begin
    rgb_d = 24'h000000;
    if (!s1_ad_q)                                  rgb_d = 24'h000000;
    else if (s1_tv_q && s1_in_q && s1_v_q == rd_q) rgb_d = 24'h00FF00;
    else if (s1_v_q == HALF_V)                     rgb_d = 24'h404040;
  end

  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      s1_v_q  <= '0;
      s1_ad_q <= 1'b0;
      s1_hs_q <= 1'b0;
      s1_vs_q <= 1'b0;
      s1_in_q <= 1'b0;
      s1_tv_q <= 1'b0;
      rgb_q   <= '0;
      hs_q    <= 1'b0;
      vs_q    <= 1'b0;
      ad_q    <= 1'b0;
    end else begin
      s1_v_q  <= v_count;
      s1_ad_q <= active_draw;
      s1_hs_q <= (h_count >= HS_START) && (h_count < HS_END);
      s1_vs_q <= (v_count >= VS_START) && (v_count < VS_END);
      s1_in_q <= h_in;
      s1_tv_q <= trace_valid_q;
      rgb_q   <= rgb_d;
      hs_q    <= s1_hs_q;
      vs_q    <= s1_vs_q;
      ad_q    <= s1_ad_q;
    end
  end

  assign red             = rgb_q[23:16];
  assign green           = rgb_q[15:8];
  assign blue            = rgb_q[7:0];
  assign hsync           = hs_q;
  assign vsync           = vs_q;
  assign active_draw_out = ad_q;

endmodule
